// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide engine.
// Op codes, FSM states and the iteration-counter sizing helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MULU  = 3'b000;
    localparam logic [2:0] OP_MULS  = 3'b001;
    localparam logic [2:0] OP_MULSU = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_DIVS  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    function automatic int cnt_width(input int rv);
        return $clog2(rv) + 1;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shifted partial remainder minus divisor, combinational.
// No state, no backpressure; result valid in the same cycle as the inputs.
module muldiv_div_step #(
    parameter int RV = 32
) (
    input  logic [RV:0]   rem_in,
    input  logic [RV-1:0] divisor,
    output logic [RV-1:0] rem_out,
    output logic          q_bit
);

    logic [RV:0] diff;

    always_comb begin
        diff    = rem_in - {1'b0, divisor};
        q_bit   = (rem_in >= {1'b0, divisor});
        // The running remainder is always below the divisor, so RV bits hold it.
        rem_out = q_bit ? RV'(diff) : RV'(rem_in);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide; done pulses N+2 cycles after an accepted start.
// Issuer must hold off while busy; start during busy is ignored, abort flushes the op in flight.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int RV      = 32,
    parameter int MUL_BPC = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [RV-1:0] a,
    input  logic [RV-1:0] b,
    input  logic          abort,
    input  logic          hi_we,
    input  logic [RV-1:0] hi_wdata,
    output logic          busy,
    output logic          done,
    output logic [RV-1:0] lo,
    output logic [RV-1:0] hi
);

    localparam int             CW       = cnt_width(RV);
    localparam int             W2       = 2 * RV;
    localparam logic [CW-1:0]  MUL_LAST = CW'(RV / MUL_BPC - 1);
    localparam logic [CW-1:0]  DIV_LAST = CW'(RV - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   p_q, p_d;
    logic [RV-1:0]   opnd_q, opnd_d;
    logic            is_div_q, is_div_d;
    logic            res_neg_q, res_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [RV-1:0]   a_raw_q, a_raw_d;
    logic [RV-1:0]   b_raw_q, b_raw_d;
    logic [RV-1:0]   lo_q, lo_d;
    logic [RV-1:0]   hi_q, hi_d;
    logic            done_q, done_d;

    logic            op_div, sa_in, sb_in;
    logic [RV-1:0]   ma_in, mb_in;

    always_comb begin
        op_div = (op == OP_DIVU) || (op == OP_DIVS);
        sa_in  = ((op == OP_MULS) || (op == OP_MULSU) || (op == OP_DIVS)) && a[RV-1];
        sb_in  = ((op == OP_MULS) || (op == OP_DIVS)) && b[RV-1];
        ma_in  = sa_in ? -a : a;
        mb_in  = sb_in ? -b : b;
    end

    // Multiply: p holds {accumulated high half, unretired multiplier bits}.
    logic [RV+MUL_BPC-1:0] pp, mul_sum;
    logic [W2-1:0]         mul_next;

    always_comb begin
        pp = '0;
        for (int j = 0; j < MUL_BPC; j++) begin
            if (p_q[j]) begin
                pp = pp + ({{MUL_BPC{1'b0}}, opnd_q} << j);
            end
        end
        mul_sum  = {{MUL_BPC{1'b0}}, p_q[W2-1:RV]} + pp;
        mul_next = {mul_sum, p_q[RV-1:MUL_BPC]};
    end

    // Divide: p holds {partial remainder, dividend bits shifting into quotient bits}.
    logic [RV:0]   div_rem_in;
    logic [RV-1:0] div_rem;
    logic          div_q;
    logic [W2-1:0] div_next;

    assign div_rem_in = {p_q[W2-1:RV], p_q[RV-1]};

    muldiv_div_step #(.RV(RV)) u_div_step (
        .rem_in  (div_rem_in),
        .divisor (opnd_q),
        .rem_out (div_rem),
        .q_bit   (div_q)
    );

    assign div_next = {div_rem, p_q[RV-2:0], div_q};

    logic [W2-1:0] prod;
    logic [RV-1:0] quo, rem, fix_lo, fix_hi;

    always_comb begin
        prod = res_neg_q ? -p_q : p_q;
        quo  = p_q[RV-1:0];
        rem  = p_q[W2-1:RV];
        if (is_div_q) begin
            if (b_raw_q == '0) begin
                fix_lo = '1;
                fix_hi = a_raw_q;
            end else begin
                fix_lo = res_neg_q ? -quo : quo;
                fix_hi = rem_neg_q ? -rem : rem;
            end
        end else begin
            fix_lo = prod[RV-1:0];
            fix_hi = prod[W2-1:RV];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        a_raw_d   = a_raw_q;
        b_raw_d   = b_raw_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hi_we) begin
                    hi_d = hi_wdata;
                end
                if (start && !abort) begin
                    state_d   = RUN;
                    cnt_d     = op_div ? DIV_LAST : MUL_LAST;
                    p_d       = {{RV{1'b0}}, op_div ? ma_in : mb_in};
                    opnd_d    = op_div ? mb_in : ma_in;
                    is_div_d  = op_div;
                    res_neg_d = sa_in ^ sb_in;
                    rem_neg_d = sa_in;
                    a_raw_d   = a;
                    b_raw_d   = b;
                end
            end
            RUN: begin
                p_d = is_div_q ? div_next : mul_next;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                state_d = IDLE;
                lo_d    = fix_lo;
                hi_d    = fix_hi;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            lo_d    = lo_q;
            hi_d    = hi_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            a_raw_q   <= '0;
            b_raw_q   <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            a_raw_q   <= a_raw_d;
            b_raw_q   <= b_raw_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model,
// on a 1-bit-per-cycle instance and a 4-bit-per-cycle instance sharing the same inputs.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, abort, hi_we;
    logic [2:0]  op;
    logic [31:0] a, b, hi_wdata;
    logic        busy, done, busy4, done4;
    logic [31:0] lo, hi, lo4, hi4;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.RV(32), .MUL_BPC(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .hi_we(hi_we), .hi_wdata(hi_wdata),
        .busy(busy), .done(done), .lo(lo), .hi(hi)
    );

    muldiv_unit #(.RV(32), .MUL_BPC(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .hi_we(hi_we), .hi_wdata(hi_wdata),
        .busy(busy4), .done(done4), .lo(lo4), .hi(hi4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results straight from integer arithmetic.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rl, output logic [31:0] rh);
        logic [63:0] p;
        longint      sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (o)
            3'b100: begin
                if (y == 0) begin rl = '1; rh = x; end
                else begin rl = x / y; rh = x % y; end
            end
            3'b101: begin
                if (y == 0) begin rl = '1; rh = x; end
                else begin
                    q = sx / sy; r = sx % sy;
                    rl = q[31:0]; rh = r[31:0];
                end
            end
            default: begin
                if (o == 3'b001)      p = sx * sy;
                else if (o == 3'b010) p = sx * longint'({32'h0, y});
                else                  p = {32'h0, x} * {32'h0, y};
                rl = p[31:0];
                rh = p[63:32];
            end
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done, counting cycles from 'from'; also records when the 4-bit instance finished.
    task automatic wait_done(input int from, output int lat, output int lat4,
                             output logic [31:0] l4, output logic [31:0] h4);
        int cyc = from;
        lat = -1; lat4 = -1; l4 = 'x; h4 = 'x;
        while (lat < 0 && cyc <= 200) begin
            if (done4 && lat4 < 0) begin
                lat4 = cyc; l4 = lo4; h4 = hi4;
            end
            if (done) lat = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] el, input logic [31:0] eh);
        int          lat, lat4;
        logic [31:0] l4, h4;
        bit          is_div;
        is_div = (o == 3'b100) || (o == 3'b101);
        issue(o, x, y);
        wait_done(1, lat, lat4, l4, h4);
        check({tag, ".lo"}, 64'(lo), 64'(el));
        check({tag, ".hi"}, 64'(hi), 64'(eh));
        check({tag, ".lat"}, 64'(lat), 64'(34));
        check({tag, ".busy_at_done"}, 64'(busy), 64'(0));
        check({tag, ".lo4"}, 64'(l4), 64'(el));
        check({tag, ".hi4"}, 64'(h4), 64'(eh));
        check({tag, ".lat4"}, 64'(lat4), is_div ? 64'(34) : 64'(10));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, lat4;
        bit          seen;
        logic [31:0] l4, h4, rl, rh, x, y;
        logic [2:0]  o;

        reset = 1'b1; start = 1'b0; abort = 1'b0; hi_we = 1'b0;
        op = 3'b000; a = '0; b = '0; hi_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.lo", 64'(lo), 64'(0));
        check("reset.hi", 64'(hi), 64'(0));
        check("reset.busy4", 64'(busy4), 64'(0));

        run_op("mulu_max",  3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("muls",      3'b001, -32'sd3, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
        run_op("mulsu",     3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_op("divs",      3'b101, -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("divu0",     3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run_op("divs0",     3'b101, -32'sd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run_op("divs_ovf",  3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        run_op("divu",      3'b100, 32'd7, 32'd2, 32'd3, 32'd1);

        // Abort in RUN at cycle 10, then restart in cycle 11.
        issue(3'b000, $urandom, $urandom);
        seen = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        if (done) seen = 1'b1;
        check("abort.busy", 64'(busy), 64'(0));
        check("abort.no_done", 64'(seen), 64'(0));
        check("abort.lo", 64'(lo), 64'(3));
        check("abort.hi", 64'(hi), 64'(1));
        issue(3'b100, 32'd20, 32'd6);
        check("abort.restart_busy", 64'(busy), 64'(1));
        wait_done(1, lat, lat4, l4, h4);
        check("abort.restart_lat", 64'(lat), 64'(34));
        check("abort.restart_lo", 64'(lo), 64'(3));
        check("abort.restart_hi", 64'(hi), 64'(2));

        // Abort together with start in IDLE drops the start.
        start = 1'b1; abort = 1'b1; op = 3'b100; a = 32'd9; b = 32'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start.busy", 64'(busy), 64'(0));

        hi_we = 1'b1; hi_wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        check("hi_we.idle", 64'(hi), 64'h1234_5678);
        check("hi_we.idle4", 64'(hi4), 64'h1234_5678);
        check("hi_we.lo_kept", 64'(lo), 64'(3));

        // hi_we and a second start during RUN are both ignored.
        issue(3'b000, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        hi_we = 1'b1; hi_wdata = 32'h0000_DEAD; start = 1'b1; op = 3'b100; a = 32'd1; b = 32'd1;
        @(negedge clk);
        hi_we = 1'b0; start = 1'b0;
        check("run_ignore.hi", 64'(hi), 64'h1234_5678);
        check("run_ignore.busy", 64'(busy), 64'(1));
        wait_done(6, lat, lat4, l4, h4);
        check("run_ignore.lat", 64'(lat), 64'(34));
        check("run_ignore.lo", 64'(lo), 64'(42));
        check("run_ignore.hi_res", 64'(hi), 64'(0));
        check("run_ignore.lat4", 64'(lat4), 64'(10));
        check("run_ignore.lo4", 64'(l4), 64'(42));

        // hi_we with start: hi written now, overwritten by the result later.
        hi_we = 1'b1; hi_wdata = 32'hABCD_0123;
        issue(3'b000, 32'd2, 32'd3);
        hi_we = 1'b0;
        check("hi_we_start.hi", 64'(hi), 64'hABCD_0123);
        check("hi_we_start.busy", 64'(busy), 64'(1));
        wait_done(1, lat, lat4, l4, h4);
        check("hi_we_start.lo", 64'(lo), 64'(6));
        check("hi_we_start.hi_res", 64'(hi), 64'(0));

        // Reset mid-operation.
        issue(3'b101, $urandom, $urandom);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset.busy", 64'(busy), 64'(0));
        check("mid_reset.lo", 64'(lo), 64'(0));
        check("mid_reset.hi", 64'(hi), 64'(0));
        @(negedge clk);
        check("mid_reset.no_done", 64'(done), 64'(0));

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            model(o, x, y, rl, rh);
            run_op($sformatf("rand%0d_op%0d", i, o), o, x, y, rl, rh);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine; successor to the single-mode shift-add multiplier embedded in the execute stage.
- Supports signed, unsigned and mixed-sign multiply, and signed or unsigned divide with remainder.
- Multiply retires MUL_BPC bits per cycle. Latency is fixed per operation.
- The execute stage issues one operation with start, stalls while busy, and reads lo/hi. hi is the architected multiplier-high register (r7) and is also writable from writeback.

Parameters:
- RV, 32, operand width; 16 or 32.
- MUL_BPC, 1, multiplier bits retired per cycle; one of 1, 2, 4, 8; must divide RV.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  issue an operation; accepted only when busy=0
- op  in  3  000 MULU, 001 MULS, 010 MULSU (a signed, b unsigned), 100 DIVU, 101 DIVS; all other codes execute as MULU
- a  in  RV  multiplicand / dividend, sampled on accept
- b  in  RV  multiplier / divisor, sampled on accept
- abort  in  1  flush the in-flight operation (trap or interrupt)
- hi_we  in  1  writeback write to hi (r7)
- hi_wdata  in  RV  data for hi_we
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; lo/hi hold the new result in this cycle
- lo  out  RV  MUL: product[RV-1:0]; DIV: quotient
- hi  out  RV  MUL: product[2RV-1:RV]; DIV: remainder

Behaviour:
- Reset state: IDLE; busy=0, done=0, lo=0, hi=0, all working registers 0.
- FSM states: IDLE, RUN, FIX.
  - IDLE→RUN on start&!busy. At accept, latch magnitudes of the signed operands, the sign flags, the op, and the raw a, b.
  - RUN holds for N cycles, then moves to FIX. N = RV/MUL_BPC for MUL ops, N = RV for DIV ops (restoring, 1 bit/cycle).
  - FIX lasts 1 cycle: apply sign correction, write lo/hi, then go to IDLE. done=1 in the first IDLE cycle.
- Latency:
  - start sampled at edge 0 gives busy=1 in cycles 1..N+1, and done=1 with busy=0 in cycle N+2.
  - A new start is legal in that same done cycle.
- Sign rules:
  - MUL: negate the 2RV-bit magnitude product when the effective signs differ.
  - DIV: quotient sign = sa^sb; remainder takes the dividend's sign.
- Divide by zero, forced in FIX: lo = all ones, hi = raw a, for both DIVU and DIVS.
- Signed overflow (DIVS of −2^(RV−1) by −1): lo = −2^(RV−1), hi = 0. Unsigned iteration produces this naturally; a bench check is required.
- lo/hi are result registers, not working registers. They change only in FIX, on reset, or (hi only) via hi_we.
- abort:
  - In RUN or FIX: next state IDLE, no done, lo/hi keep their previous values.
  - In IDLE: no effect.
  - abort and start in the same cycle: abort wins; the start is dropped.
- start while busy: ignored; operands are not re-sampled.
- hi_we:
  - Applied only when busy=0. hi_we while busy is ignored.
  - hi_we with start in the same cycle: hi is written and the operation is accepted.
  - The operation's FIX later overwrites hi.
- reset mid-operation: returns to the reset state on the next edge; no done.
- All arithmetic is modulo 2RV internally; outputs are truncated to RV.

Decomposition:
- muldiv_pkg: op encodings (MULU, MULS, MULSU, DIVU, DIVS), state enum (IDLE/RUN/FIX), iteration-counter width function clog2(RV)+1.
- Sub-module muldiv_div_step: combinational restoring-division step. Inputs: partial remainder and divisor. Outputs: next remainder and quotient bit.
- The multiply step stays inline as an adder tree of MUL_BPC shifted partial products.

Test Plan:
- MULU a=0xFFFFFFFF b=0xFFFFFFFF, MUL_BPC=1 → lo=0x00000001, hi=0xFFFFFFFE, done exactly 34 cycles after start; with MUL_BPC=4, done after 10 cycles.
- MULS a=−3 b=7 → lo=0xFFFFFFEB, hi=0xFFFFFFFF. MULSU a=0xFFFFFFFF b=2 → lo=0xFFFFFFFE, hi=0xFFFFFFFF.
- DIVS a=−7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 → lo=3, hi=1. Both complete in 34 cycles.
- DIVU a=5 b=0 → lo=0xFFFFFFFF, hi=5. DIVS a=−5 b=0 → lo=0xFFFFFFFF, hi=0xFFFFFFFB. DIVS a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Prior result lo=3, hi=1, then MULU started and abort asserted at cycle 10 → busy=0 at cycle 11, no done, lo=3, hi=1; a start in cycle 11 is accepted.
- Idle hi_we with 0x12345678 → hi=0x12345678 next cycle. During RUN, hi_we with 0xDEAD and a second start → both ignored, and the first result is unchanged.
